// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
//   Decoupling queue between instruction fetch (IF) and decode (ID). Each
//   fetched {pc_plus4, instruction} pair is stored in order. The oldest entry
//   is presented to ID. Fetch is told to hold while the queue is nearly full.
//   A taken branch (flush) discards every queued wrong-path entry in one cycle.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-low (0 = reset)
//   fetch_valid  in   a new fetch beat is present on pc_plus4_in/inst_in
//   pc_plus4_in  in   [ADDR_W] pc_plus4 from fetch
//   inst_in      in   [INST_W] instruction word from the ROM
//   flush        in   taken branch: drop the queue and this cycle's fetch
//   id_stall     in   ID cannot take the head entry this cycle
//   id_valid     out  head entry is valid
//   id_pc_plus4  out  [ADDR_W] head pc_plus4, 0 when empty
//   id_inst      out  [INST_W] head instruction, 0 (NOP) when empty
//   if_hold      out  fetch must not advance
//   overflow     out  sticky: a push was attempted into a full queue
//
// Handshake: the write side transfers on fetch_valid & ~flush (if_hold is
// advisory back-pressure, the queue keeps one spare slot for the beat already
// in flight). The read side transfers on id_valid & ~id_stall & ~flush.
// Flush overrides both sides.
// -----------------------------------------------------------------------------
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] pc_plus4_in,
  input  logic [INST_W-1:0] inst_in,
  input  logic              flush,
  input  logic              id_stall,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic [INST_W-1:0] id_inst,
  output logic              if_hold,
  output logic              overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + INST_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             overflow_q, overflow_d;

  logic push;
  logic pop;
  logic full;
  logic push_ok;

  logic [ENTRY_W-1:0] head;

  assign push = fetch_valid & ~flush;
  assign pop  = id_valid & ~id_stall & ~flush;
  assign full = (count_q == CNT_W'(DEPTH));

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & ~push_ok);

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: an entry is only read once count covers it.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {pc_plus4_in, inst_in};
  end

  assign head        = mem_q[rd_ptr_q];
  assign id_valid    = (count_q != '0);
  assign id_pc_plus4 = id_valid ? head[ENTRY_W-1:INST_W] : '0;
  assign id_inst     = id_valid ? head[INST_W-1:0]       : '0;

  // Decoded from the registered count only, so it cannot glitch.
  assign if_hold  = (count_q >= CNT_W'(DEPTH - 1));
  assign overflow = overflow_q;

endmodule

// File: tb/tb_if_id_queue.sv
// -----------------------------------------------------------------------------
// tb_if_id_queue
//   Self-checking bench for if_id_queue (DEPTH=4). A queue-based reference
//   model tracks the expected contents; each scenario task also checks the
//   scenario's expected values directly.
// -----------------------------------------------------------------------------
module tb_if_id_queue;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int VEC_W  = 1 + ADDR_W + INST_W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              fetch_valid = 1'b0;
  logic [ADDR_W-1:0] pc_plus4_in = '0;
  logic [INST_W-1:0] inst_in     = '0;
  logic              flush       = 1'b0;
  logic              id_stall    = 1'b0;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc_plus4;
  logic [INST_W-1:0] id_inst;
  logic              if_hold;
  logic              overflow;

  if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .pc_plus4_in (pc_plus4_in),
    .inst_in     (inst_in),
    .flush       (flush),
    .id_stall    (id_stall),
    .id_valid    (id_valid),
    .id_pc_plus4 (id_pc_plus4),
    .id_inst     (id_inst),
    .if_hold     (if_hold),
    .overflow    (overflow)
  );

  wire [VEC_W-1:0] dut_vec = {id_valid, id_pc_plus4, id_inst, if_hold, overflow};

  // ---------------- reference model ----------------
  logic [ADDR_W+INST_W-1:0] exp_q[$];
  logic                     ovf_m = 1'b0;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [VEC_W-1:0] model_vec();
    logic              v;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] in;
    v  = (exp_q.size() != 0);
    pc = v ? exp_q[0][ADDR_W+INST_W-1:INST_W] : '0;
    in = v ? exp_q[0][INST_W-1:0] : '0;
    return {v, pc, in, (exp_q.size() >= DEPTH - 1), ovf_m};
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; leaves time at the following falling edge.
  task automatic drive(input logic fv, input logic [ADDR_W-1:0] pc,
                       input logic fl, input logic st);
    fetch_valid = fv;
    pc_plus4_in = pc;
    inst_in     = $urandom;
    flush       = fl;
    id_stall    = st;
    @(negedge clk);
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic tick();
    logic do_push;
    logic do_pop;
    int   sz;
    @(posedge clk);
    do_push = fetch_valid && !flush;
    do_pop  = (exp_q.size() != 0) && !id_stall && !flush;
    sz      = exp_q.size();
    if (flush) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        if (sz < DEPTH || do_pop) exp_q.push_back({pc_plus4_in, inst_in});
        else ovf_m = 1'b1;
      end
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_vec++;
    if (dut_vec !== {VEC_W{1'b0}}) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected %h", dut_vec, {VEC_W{1'b0}});
    end
    tick();
  endtask

  task automatic test_in_order();
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, (i < 3) ? ADDR_W'(4 * (i + 1)) : '0, 1'b0, 1'b0);
      n_vec++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        $display("FAIL in_order_model cyc%0d: got %h expected %h", i, dut_vec, model_vec());
      end
      if (i >= 1 && i <= 3) begin
        n_vec++;
        if (id_pc_plus4 !== ADDR_W'(4 * i) || id_valid !== 1'b1) begin
          n_err++;
          $display("FAIL in_order_head cyc%0d: got v=%b pc=%0d expected v=1 pc=%0d",
                   i, id_valid, id_pc_plus4, 4 * i);
        end
      end
      tick();
    end
  endtask

  task automatic test_hold();
    logic [ADDR_W-1:0] exp_pc [4];
    logic              exp_hold [4];
    exp_pc   = '{32'd4, 32'd8, 32'd12, 32'd0};
    exp_hold = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, ADDR_W'(4 * (i + 1)), 1'b0, 1'b1);
      n_vec++;
      if (dut_vec !== model_vec() || if_hold !== (i == 3)) begin
        n_err++;
        $display("FAIL hold_fill cyc%0d: got %h hold=%b expected %h", i, dut_vec, if_hold, model_vec());
      end
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      n_vec++;
      if (dut_vec !== model_vec() || id_pc_plus4 !== exp_pc[j] || if_hold !== exp_hold[j]) begin
        n_err++;
        $display("FAIL hold_drain cyc%0d: got pc=%0d hold=%b expected pc=%0d hold=%b",
                 j, id_pc_plus4, if_hold, exp_pc[j], exp_hold[j]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDR_W'(32'h20 + 4 * i), 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 32'h2c, 1'b1, 1'b0);
    n_vec++;
    if (dut_vec !== model_vec() || id_valid !== 1'b1) begin
      n_err++;
      $display("FAIL flush_before: got %h expected %h", dut_vec, model_vec());
    end
    tick();
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    n_vec++;
    if (dut_vec !== model_vec() || id_valid !== 1'b0 || if_hold !== 1'b0) begin
      n_err++;
      $display("FAIL flush_empty: got v=%b hold=%b expected v=0 hold=0", id_valid, if_hold);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_vec++;
    if (dut_vec !== model_vec() || id_pc_plus4 !== 32'h100 || id_valid !== 1'b1) begin
      n_err++;
      $display("FAIL flush_target: got v=%b pc=%h expected v=1 pc=100", id_valid, id_pc_plus4);
    end
    tick();
  endtask

  task automatic test_full();
    logic [ADDR_W-1:0] exp_pc [4];
    exp_pc = '{32'h20, 32'h30, 32'h40, 32'h50};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ADDR_W'(32'h10 * (i + 1)), 1'b0, 1'b1);
      tick();
    end
    // Full: push with pop keeps four entries.
    drive(1'b1, 32'h50, 1'b0, 1'b0);
    n_vec++;
    if (dut_vec !== model_vec() || id_pc_plus4 !== 32'h10 || if_hold !== 1'b1) begin
      n_err++;
      $display("FAIL full_head: got pc=%h hold=%b expected pc=10 hold=1", id_pc_plus4, if_hold);
    end
    tick();
    // Still full: push without pop is dropped.
    drive(1'b1, 32'h60, 1'b0, 1'b1);
    n_vec++;
    if (dut_vec !== model_vec() || id_pc_plus4 !== 32'h20 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL full_pushpop: got pc=%h ovf=%b expected pc=20 ovf=0", id_pc_plus4, overflow);
    end
    tick();
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      n_vec++;
      if (dut_vec !== model_vec() || overflow !== 1'b1 ||
          (j < 4 && id_pc_plus4 !== exp_pc[j]) || (j == 4 && id_valid !== 1'b0)) begin
        n_err++;
        $display("FAIL full_drain cyc%0d: got v=%b pc=%h ovf=%b expected pc=%h ovf=1",
                 j, id_valid, id_pc_plus4, overflow, (j < 4) ? exp_pc[j] : 32'h0);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ADDR_W'(32'h200 + 4 * i), 1'b0, 1'b1);
      tick();
    end
    fetch_valid = 1'b0;
    id_stall    = 1'b1;
    n_vec++;
    if (id_valid !== 1'b1 || if_hold !== 1'b1 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL areset_pre: got v=%b hold=%b ovf=%b expected 1 1 1", id_valid, if_hold, overflow);
    end
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if (dut_vec !== {VEC_W{1'b0}}) begin
      n_err++;
      $display("FAIL areset_mid: got %h expected %h", dut_vec, {VEC_W{1'b0}});
    end
    exp_q.delete();
    ovf_m = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0);
    n_vec++;
    if (dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL areset_after: got %h expected %h", dut_vec, model_vec());
    end
    tick();
  endtask

  task automatic test_wrap_random();
    logic fv, fl, st;
    for (int i = 0; i < 80; i++) begin
      fl = ($urandom_range(0, 15) == 0);
      st = ($urandom_range(0, 2) == 0);
      // Mostly honour the hold; occasionally fetch anyway to reach full.
      fv = ($urandom_range(0, 3) != 0) && (!(exp_q.size() >= DEPTH - 1) || $urandom_range(0, 3) == 0);
      drive(fv, $urandom, fl, st);
      n_vec++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        $display("FAIL random cyc%0d: got %h expected %h", i, dut_vec, model_vec());
      end
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    #12 rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_in_order();
    test_hold();
    test_flush();
    test_full();
    test_async_reset();
    test_wrap_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
